// File: rtl/clk_gate_seq_pkg.sv
// Shared types and helpers for the clock-gate sequencer.
package clk_gate_seq_pkg;

   // Per-domain clock state: OFF (gated), SETTLE (clock running, not yet acked),
   // ON (running and acked), DRAIN (idle countdown towards gate-off).
   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SETTLE = 2'd1,
      ON     = 2'd2,
      DRAIN  = 2'd3
   } dom_state_e;

   // Bits needed by a down-counter that is loaded with (cycles-1); never below 1.
   function automatic int cnt_w(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/clk_gate_domain_fsm.sv
// One gated clock domain: OFF -> SETTLE -> ON <-> DRAIN -> OFF.
// req_i here is the combined request (req | force_on) built by the top.
module clk_gate_domain_fsm
   import clk_gate_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int IDLE_W        = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              busy_i,
   input  logic              grant_i,
   input  logic [IDLE_W-1:0] idle_thresh_i,
   output logic              cand_o,
   output logic              gate_en_o,
   output logic              ack_o,
   output dom_state_e        state_o
);

   localparam int            SW          = cnt_w(SETTLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   dom_state_e        state_q, state_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              gate_q, ack_q;

   // Next-state logic: SETTLE always runs to completion; DRAIN gives priority
   // to a new request, then to activity, then to the idle timeout.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      idle_d   = idle_q;
      case (state_q)
         OFF: begin
            if (req_i && grant_i) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (settle_q == '0) state_d = ON;
            else                settle_d = settle_q - 1'b1;
         end
         ON: begin
            if (!req_i && !busy_i) begin
               state_d = DRAIN;
               idle_d  = idle_thresh_i;
            end
         end
         DRAIN: begin
            if (req_i)              state_d = ON;
            else if (busy_i)        idle_d  = idle_thresh_i;
            else if (idle_q == '0)  state_d = OFF;
            else                    idle_d  = idle_q - 1'b1;
         end
         default: state_d = OFF;
      endcase
   end

   // State, counters and registered output decodes (glitch-free gate enable).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= OFF;
         settle_q <= '0;
         idle_q   <= '0;
         gate_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         idle_q   <= idle_d;
         gate_q   <= (state_d != OFF);
         ack_q    <= (state_d == ON) || (state_d == DRAIN);
      end
   end

   assign cand_o    = (state_q == OFF) && req_i;
   assign gate_en_o = gate_q;
   assign ack_o     = ack_q;
   assign state_o   = state_q;

endmodule

// File: rtl/clk_gate_sequencer.sv
// Clock-gate sequencer: per-domain FSMs, a round-robin wake arbiter with a
// stagger counter spacing successive grants, and the scan-mode override.
// Handshake: req_i is a level (four-phase); ack_o rises once the domain clock
// is settled and falls only on the same edge as gate_en_o; the requester waits
// for ack_o=0 before raising req_i again, otherwise it is taken as a new request.
module clk_gate_sequencer
   import clk_gate_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = 4,
   parameter int IDLE_W         = 8,
   parameter int SETTLE_CYCLES  = 2,
   parameter int STAGGER_CYCLES = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_DOMAINS-1:0] req_i,
   input  logic [NUM_DOMAINS-1:0] busy_i,
   input  logic [NUM_DOMAINS-1:0] force_on_i,
   input  logic [IDLE_W-1:0]      idle_thresh_i,
   input  logic                   test_en_i,
   output logic [NUM_DOMAINS-1:0] gate_en_o,
   output logic [NUM_DOMAINS-1:0] ack_o
);

   localparam int               PTR_W        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam int               STG_W        = cnt_w(STAGGER_CYCLES);
   localparam logic [STG_W-1:0] STAGGER_LOAD = STG_W'(STAGGER_CYCLES - 1);

   logic [NUM_DOMAINS-1:0] r, cand, grant, dom_gate, dom_ack;
   dom_state_e             dom_state [NUM_DOMAINS];
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [STG_W-1:0]       stagger_q, stagger_d;

   assign r = req_i | force_on_i;

   // Round-robin pick of the first candidate at or after the pointer, only
   // while the stagger counter is idle; a grant reloads the stagger counter.
   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      rr_ptr_d  = rr_ptr_q;
      stagger_d = stagger_q;
      idx       = 0;
      found     = 1'b0;
      if (stagger_q != '0) begin
         stagger_d = stagger_q - 1'b1;
      end else begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_DOMAINS;
            if (!found && cand[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               rr_ptr_d   = PTR_W'((idx + 1) % NUM_DOMAINS);
               stagger_d  = STAGGER_LOAD;
            end
         end
      end
   end

   // Arbiter pointer and stagger counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q  <= '0;
         stagger_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         stagger_q <= stagger_d;
      end
   end

   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
      clk_gate_domain_fsm #(
         .SETTLE_CYCLES (SETTLE_CYCLES),
         .IDLE_W        (IDLE_W)
      ) u_dom (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .req_i         (r[g]),
         .busy_i        (busy_i[g]),
         .grant_i       (grant[g]),
         .idle_thresh_i (idle_thresh_i),
         .cand_o        (cand[g]),
         .gate_en_o     (dom_gate[g]),
         .ack_o         (dom_ack[g]),
         .state_o       (dom_state[g])
      );

      // Only a gated-off domain may compete for a wake grant.
      a_cand_off: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   cand[g] |-> dom_state[g] == OFF);
   end

   // At most one wake grant per cycle.
   a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant));

   assign gate_en_o = dom_gate | {NUM_DOMAINS{test_en_i}};
   assign ack_o     = dom_ack;

endmodule
